// File: rtl/mul4_arbiter.sv
// mul4_arbiter: round-robin arbiter and sequencer sharing one unsigned 4x4
// multiplier among NREQ requesters.
//
// Build option: define MUL4_ARB_BYPASS_EN to skip the MUL state. The product
// is then computed from the granted request's operands and registered at the
// handshake edge, which gives a 1-cycle latency.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   req_valid  [NREQ]    per-requester operand pair valid
//   req_a      [4*NREQ]  operand A, requester i in bits [4i+3:4i]
//   req_b      [4*NREQ]  operand B, requester i in bits [4i+3:4i]
//   req_ready  [NREQ]    one-hot grant (zero outside IDLE and during reset)
//   rsp_valid            product available
//   rsp_ready            consumer accepts product
//   rsp_y      [8]       unsigned product
//   rsp_id     [ID_W]    owner of rsp_y

// Combinational unsigned 4x4 multiplier built from shifted partial products.
module bit4_multiplier (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [7:0] y
);
   logic [3:0][7:0] pp;

   for (genvar i = 0; i < 4; i++) begin : g_pp
      assign pp[i] = b[i] ? ({4'b0000, a} << i) : 8'h00;
   end

   assign y = pp[0] + pp[1] + pp[2] + pp[3];
endmodule

module mul4_arbiter #(
   parameter int NREQ = 4,
   parameter int ID_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [4*NREQ-1:0] req_a,
   input  logic [4*NREQ-1:0] req_b,
   output logic [NREQ-1:0]   req_ready,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [7:0]        rsp_y,
   output logic [ID_W-1:0]   rsp_id
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_RSP  = 2'd2
   } state_t;

   state_t          state, state_nx;
   logic [ID_W-1:0] ptr, ptr_nx;
   logic [3:0]      op_a, op_b;
   logic [ID_W-1:0] id_q;

   logic            gnt_any;
   logic [ID_W-1:0] gnt_idx;
   logic [3:0]      gnt_a, gnt_b;
   logic            hs;
   logic [3:0]      mul_a, mul_b;
   logic [7:0]      mul_y;

   // Round-robin scan: first valid requester at or above ptr, wrapping
   // modulo NREQ (NREQ need not be a power of two).
   always_comb begin
      int j;
      j       = 0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      gnt_a   = 4'h0;
      gnt_b   = 4'h0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!gnt_any && req_valid[j]) begin
            gnt_any = 1'b1;
            gnt_idx = ID_W'(j);
            gnt_a   = req_a[4*j +: 4];
            gnt_b   = req_b[4*j +: 4];
         end
      end
   end

   // Handshake happens only in IDLE; the async reset takes priority in the
   // register block, so no handshake completes on an edge under reset.
   assign hs = (state == S_IDLE) && gnt_any && !rst;

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (hs && (gnt_idx == ID_W'(i))) req_ready[i] = 1'b1;
      end
   end

   assign ptr_nx = (gnt_idx == ID_W'(NREQ-1)) ? '0 : gnt_idx + 1'b1;

`ifdef MUL4_ARB_BYPASS_EN
   assign mul_a = gnt_a;
   assign mul_b = gnt_b;
`else
   assign mul_a = op_a;
   assign mul_b = op_b;
`endif

   bit4_multiplier u_mul (
      .a (mul_a),
      .b (mul_b),
      .y (mul_y)
   );

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
`ifdef MUL4_ARB_BYPASS_EN
            if (gnt_any) state_nx = S_RSP;
`else
            if (gnt_any) state_nx = S_MUL;
`endif
         end
         S_MUL:   state_nx = S_RSP;
         S_RSP:   if (rsp_ready) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         ptr    <= '0;
         op_a   <= 4'h0;
         op_b   <= 4'h0;
         id_q   <= '0;
         rsp_y  <= 8'h00;
         rsp_id <= '0;
      end else begin
         state <= state_nx;
         if (hs) begin
            op_a <= gnt_a;
            op_b <= gnt_b;
            id_q <= gnt_idx;
            ptr  <= ptr_nx;
`ifdef MUL4_ARB_BYPASS_EN
            rsp_y  <= mul_y;
            rsp_id <= gnt_idx;
`endif
         end
`ifndef MUL4_ARB_BYPASS_EN
         if (state == S_MUL) begin
            rsp_y  <= mul_y;
            rsp_id <= id_q;
         end
`endif
      end
   end

   // Decoded from state so the async reset drops it immediately.
   assign rsp_valid = (state == S_RSP);
endmodule

// File: tb/tb_mul4_arbiter.sv
// Directed self-checking bench for mul4_arbiter (default build, NREQ=4).
module tb_mul4_arbiter;
   localparam int NREQ = 4;
   localparam int ID_W = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [NREQ-1:0]   req_valid = '0;
   logic [4*NREQ-1:0] req_a = '0;
   logic [4*NREQ-1:0] req_b = '0;
   logic [NREQ-1:0]   req_ready;
   logic              rsp_valid;
   logic              rsp_ready = 1'b1;
   logic [7:0]        rsp_y;
   logic [ID_W-1:0]   rsp_id;

   int n_chk  = 0;
   int n_fail = 0;
   int hs_cnt = 0;
   int rsp_cnt = 0;

   mul4_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_y     (rsp_y),
      .rsp_id    (rsp_id)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if ((req_ready & req_valid) != '0) hs_cnt++;
      if (rsp_valid && rsp_ready) rsp_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      #1;
   endtask

   // Present a request and wait (bounded) for its grant; drop valid after the
   // handshake edge.
   task automatic do_req(input int idx, input logic [3:0] a, input logic [3:0] b,
                         input string tag);
      int t;
      req_a[4*idx +: 4] = a;
      req_b[4*idx +: 4] = b;
      req_valid[idx]    = 1'b1;
      #1;
      t = 0;
      while (!req_ready[idx] && t < 20) begin
         step();
         t++;
      end
      chk({tag, "_gnt"}, 32'(req_ready[idx]), 32'd1);
      step();
      req_valid[idx] = 1'b0;
   endtask

   // Wait (bounded) for a response, check it, accept it if rsp_ready is high.
   task automatic wait_rsp(input string tag, input logic [7:0] ey, input int eid);
      int t;
      t = 0;
      while (!rsp_valid && t < 20) begin
         step();
         t++;
      end
      chk({tag, "_vld"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_y"}, 32'(rsp_y), 32'(ey));
      chk({tag, "_id"}, 32'(rsp_id), eid);
      if (rsp_ready) step();
   endtask

   initial begin
      // Reset: grants suppressed even with all requests pending.
      rst = 1'b1;
      req_valid = 4'b1111;
      #1;
      chk("rst_ready", 32'(req_ready), 32'd0);
      step();
      chk("rst_vld", 32'(rsp_valid), 32'd0);
      chk("rst_y", 32'(rsp_y), 32'd0);
      chk("rst_id", 32'(rsp_id), 32'd0);
      req_valid = '0;
      step();
      rst = 1'b0;
      #1;

      // Single request, 2-cycle latency, 1-cycle response.
      req_a[3:0] = 4'd3;
      req_b[3:0] = 4'd5;
      req_valid  = 4'b0001;
      #1;
      chk("t1_ready", 32'(req_ready), 32'h1);
      step();                               // edge T
      req_valid = '0;
      chk("t1_mul_ready", 32'(req_ready), 32'h0);
      chk("t1_vld_T1", 32'(rsp_valid), 32'd0);
      step();                               // edge T+1
      chk("t1_vld_T2", 32'(rsp_valid), 32'd1);
      chk("t1_y", 32'(rsp_y), 32'd15);
      chk("t1_id", 32'(rsp_id), 32'd0);
      step();                               // accepted
      chk("t1_vld_after", 32'(rsp_valid), 32'd0);

      // All requesters held: rotation 0,1,2,3,0.
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         req_a[4*i +: 4] = 4'(i + 1);
         req_b[4*i +: 4] = 4'd2;
      end
      req_valid = 4'b1111;
      begin
         int exp_id[5] = '{0, 1, 2, 3, 0};
         int exp_y[5]  = '{2, 4, 6, 8, 2};
         for (int n = 0; n < 5; n++) begin
            int t;
            t = 0;
            while (!rsp_valid && t < 20) begin
               step();
               t++;
            end
            chk($sformatf("rr%0d_vld", n), 32'(rsp_valid), 32'd1);
            chk($sformatf("rr%0d_id", n), 32'(rsp_id), exp_id[n]);
            chk($sformatf("rr%0d_y", n), 32'(rsp_y), exp_y[n]);
            step();
            if (n == 4) req_valid = '0;
         end
      end

      // Backpressure: product held, no grants until accepted.
      do_reset();
      rsp_ready = 1'b0;
      do_req(2, 4'hF, 4'hF, "bp");
      step();                               // now in RSP
      req_a[3:0] = 4'd1;
      req_b[3:0] = 4'd1;
      req_valid[0] = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk($sformatf("bp%0d_vld", c), 32'(rsp_valid), 32'd1);
         chk($sformatf("bp%0d_y", c), 32'(rsp_y), 32'hE1);
         chk($sformatf("bp%0d_id", c), 32'(rsp_id), 32'd2);
         chk($sformatf("bp%0d_ready", c), 32'(req_ready), 32'd0);
         step();
      end
      rsp_ready = 1'b1;
      step();                               // accepting edge
      chk("bp_next_gnt", 32'(req_ready), 32'h1);
      step();
      req_valid = '0;
      wait_rsp("bp_next", 8'd1, 0);

      // ptr wrap: after granting 3, requesters 0 and 3 pending -> 0 wins.
      do_reset();
      do_req(3, 4'd2, 4'd2, "wrap3");
      wait_rsp("wrap3", 8'd4, 3);
      req_a[3:0] = 4'd5;
      req_b[3:0] = 4'd5;
      req_valid  = 4'b1001;
      #1;
      chk("wrap_gnt", 32'(req_ready), 32'h1);
      step();
      req_valid = '0;
      wait_rsp("wrap0", 8'd25, 0);

      // Reset during MUL discards the request; async drop during RSP.
      do_reset();
      req_a[3:0] = 4'd9;
      req_b[3:0] = 4'd7;
      req_valid  = 4'b0001;
      #1;
      step();                               // handshake, now MUL
      req_valid = '0;
      rst = 1'b1;
      #1;
      chk("rmul_vld", 32'(rsp_valid), 32'd0);
      chk("rmul_ready", 32'(req_ready), 32'd0);
      step();
      step();
      chk("rmul_y", 32'(rsp_y), 32'd0);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         chk($sformatf("rmul_none%0d", c), 32'(rsp_valid), 32'd0);
      end
      do_req(1, 4'd2, 4'd3, "rmul_new");
      wait_rsp("rmul_new", 8'd6, 1);

      rsp_ready = 1'b0;
      do_req(0, 4'd4, 4'd4, "rrsp");
      step();
      chk("rrsp_vld_pre", 32'(rsp_valid), 32'd1);
      #2;                                   // mid-cycle async reset
      rst = 1'b1;
      #1;
      chk("rrsp_vld_drop", 32'(rsp_valid), 32'd0);
      step();
      rst = 1'b0;
      rsp_ready = 1'b1;
      #1;

      // Exhaustive sweep through requester 1.
      do_reset();
      hs_cnt  = 0;
      rsp_cnt = 0;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            do_req(1, 4'(a), 4'(b), $sformatf("sw_%0d_%0d", a, b));
            wait_rsp($sformatf("sw_%0d_%0d", a, b), 8'(a * b), 1);
         end
      end
      chk("sw_hs_cnt", 32'(hs_cnt), 32'd256);
      chk("sw_rsp_cnt", 32'(rsp_cnt), 32'd256);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
